// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Decode-stage hazard and forwarding controller. It tracks the destination
//   of the instructions in EX and MEM, and uses them to choose forwarding
//   paths, to insert load-use bubbles, and to flush IF/ID on taken branches.
//   After an HLT has issued, a drain FSM lets EX, MEM and WB empty. Then
//   Halted is asserted and held until reset.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   ID_Valid                 instruction in ID is real (not a bubble)
//   SrcReg1/2, Src1/2_Used   ID source registers and their read enables
//   DstReg, RF_WrDec         ID destination register and its write enable
//   LoadDec, HltDec          ID instruction is a load / HLT
//   BranchTaken              branch in ID resolved taken
//   MemStall                 memory busy: freeze the whole pipeline
//   PC_WriteEnable           PC update enable
//   IFID_WriteEnable         IF/ID register enable
//   IFID_Flush               squash IF/ID contents
//   IDEX_WriteEnable         ID/EX register enable
//   IDEX_Noop                ID/EX bubble insert
//   XX_Reg1/2, MX_Reg1/2     EX->EX and MEM->EX forward selects
//   LoadUseStall             load-use bubble this cycle
//   Halted                   pipeline drained after HLT
//   StallCount               saturating count of load-use stall cycles
module hazard_forward_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_Valid,
  input  logic [3:0]       SrcReg1,
  input  logic [3:0]       SrcReg2,
  input  logic             Src1_Used,
  input  logic             Src2_Used,
  input  logic [3:0]       DstReg,
  input  logic             RF_WrDec,
  input  logic             LoadDec,
  input  logic             HltDec,
  input  logic             BranchTaken,
  input  logic             MemStall,
  output logic             PC_WriteEnable,
  output logic             IFID_WriteEnable,
  output logic             IFID_Flush,
  output logic             IDEX_WriteEnable,
  output logic             IDEX_Noop,
  output logic             XX_Reg1,
  output logic             XX_Reg2,
  output logic             MX_Reg1,
  output logic             MX_Reg2,
  output logic             LoadUseStall,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state;
  logic [DCNT_W-1:0] drainCnt;
  logic              haltedQ;
  logic [CNT_W-1:0]  stallCnt;

  // EX slot (p1) and MEM slot (p2) of the in-flight scoreboard
  logic [3:0] dst_p1;
  logic       wr_p1;
  logic       load_p1;
  logic       vld_p1;
  logic [3:0] dst_p2;
  logic       wr_p2;
  logic       vld_p2;

  logic exHit1, exHit2, memHit1, memHit2;
  logic loadUse, issue;
  logic xx1, xx2, mx1, mx2;
  logic noop;

  function automatic logic slotMatch(input logic [3:0] src, input logic [3:0] dst,
                                     input logic wr, input logic vld);
    return vld & wr & (dst == src) & (src != 4'd0);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ID stage: hazard detection and forward selection
  assign exHit1  = Src1_Used & slotMatch(SrcReg1, dst_p1, wr_p1, vld_p1);
  assign exHit2  = Src2_Used & slotMatch(SrcReg2, dst_p1, wr_p1, vld_p1);
  assign memHit1 = Src1_Used & slotMatch(SrcReg1, dst_p2, wr_p2, vld_p2);
  assign memHit2 = Src2_Used & slotMatch(SrcReg2, dst_p2, wr_p2, vld_p2);

  assign loadUse = (state == RUN) & ID_Valid & load_p1 & (exHit1 | exHit2);
  assign issue   = (state == RUN) & ID_Valid & ~loadUse;

  // A load in EX cannot forward from EX, so that case is left to the stall
  assign xx1 = exHit1 & ~load_p1;
  assign xx2 = exHit2 & ~load_p1;
  assign mx1 = memHit1 & ~xx1;
  assign mx2 = memHit2 & ~xx2;

  always_comb begin
    PC_WriteEnable   = 1'b1;
    IFID_WriteEnable = 1'b1;
    IDEX_WriteEnable = 1'b1;
    noop             = ~ID_Valid;
    // an accepted HLT wins over a simultaneous taken branch; drain stops fetch
    IFID_Flush       = ID_Valid & BranchTaken & ~HltDec;
    if (!rst) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      noop             = 1'b1;
      IFID_Flush       = 1'b0;
    end else if (MemStall) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      IDEX_WriteEnable = 1'b0;
      noop             = 1'b0;
      IFID_Flush       = 1'b0;
    end else if (state == HALTED) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      IDEX_WriteEnable = 1'b0;
      noop             = 1'b1;
      IFID_Flush       = 1'b0;
    end else if (state == DRAIN || loadUse) begin
      PC_WriteEnable   = 1'b0;
      IFID_WriteEnable = 1'b0;
      noop             = 1'b1;
      IFID_Flush       = 1'b0;
    end
  end

  assign IDEX_Noop    = noop;
  assign XX_Reg1      = rst & ~noop & xx1;
  assign XX_Reg2      = rst & ~noop & xx2;
  assign MX_Reg1      = rst & ~noop & mx1;
  assign MX_Reg2      = rst & ~noop & mx2;
  assign LoadUseStall = rst & loadUse;
  assign Halted       = haltedQ;
  assign StallCount   = stallCnt;

  // EX/MEM boundary: scoreboard control, drain FSM, stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      state    <= RUN;
      drainCnt <= DCNT_W'(DRAIN_CYCLES);
      haltedQ  <= 1'b0;
      stallCnt <= '0;
    end else if (!MemStall) begin
      vld_p2 <= vld_p1;
      vld_p1 <= issue;
      if (loadUse) stallCnt <= satInc(stallCnt);
      case (state)
        RUN: begin
          if (issue && HltDec) begin
            // the acceptance edge is the first of the drain cycles
            drainCnt <= DCNT_W'(DRAIN_CYCLES - 1);
            if (DRAIN_CYCLES <= 1) begin
              state   <= HALTED;
              haltedQ <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drainCnt <= drainCnt - DCNT_W'(1);
          if (drainCnt <= DCNT_W'(1)) begin
            state   <= HALTED;
            haltedQ <= 1'b1;
          end
        end
        default: begin
          state   <= HALTED;
          haltedQ <= 1'b1;
        end
      endcase
    end
  end

  // EX/MEM boundary: scoreboard payload (qualified by vld_p1/vld_p2)
  always_ff @(posedge clk) begin
    if (!MemStall) begin
      dst_p2 <= dst_p1;
      wr_p2  <= wr_p1;
      if (issue) begin
        dst_p1  <= DstReg;
        wr_p1   <= RF_WrDec;
        load_p1 <= LoadDec;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid, Src1_Used, Src2_Used, RF_WrDec, LoadDec, HltDec, BranchTaken, MemStall;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable, IDEX_Noop;
  logic        XX_Reg1, XX_Reg2, MX_Reg1, MX_Reg2, LoadUseStall, Halted;
  logic [15:0] StallCount;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .Src1_Used(Src1_Used), .Src2_Used(Src2_Used), .DstReg(DstReg), .RF_WrDec(RF_WrDec),
    .LoadDec(LoadDec), .HltDec(HltDec), .BranchTaken(BranchTaken), .MemStall(MemStall),
    .PC_WriteEnable(PC_WriteEnable), .IFID_WriteEnable(IFID_WriteEnable),
    .IFID_Flush(IFID_Flush), .IDEX_WriteEnable(IDEX_WriteEnable), .IDEX_Noop(IDEX_Noop),
    .XX_Reg1(XX_Reg1), .XX_Reg2(XX_Reg2), .MX_Reg1(MX_Reg1), .MX_Reg2(MX_Reg2),
    .LoadUseStall(LoadUseStall), .Halted(Halted), .StallCount(StallCount)
  );

  // {PC, IFID, Flush, IDEX_WE, Noop, XX1, XX2, MX1, MX2, LoadUseStall, Halted}
  localparam logic [10:0] RUN_ISS = 11'b11010000000;
  localparam logic [10:0] RUN_BUB = 11'b11011000000;
  localparam logic [10:0] STALL   = 11'b00011000010;
  localparam logic [10:0] DRAINV  = 11'b00011000000;
  localparam logic [10:0] RSTV    = 11'b00011000000;
  localparam logic [10:0] HALTV   = 11'b00001000001;
  localparam logic [10:0] FROZEN  = 11'b00000000000;
  localparam logic [10:0] F_FL    = 11'b00100000000;
  localparam logic [10:0] F_XX1   = 11'b00000100000;
  localparam logic [10:0] F_MX1   = 11'b00000001000;
  localparam logic [10:0] F_MX2   = 11'b00000000100;
  localparam logic [10:0] F_LUS   = 11'b00000000010;
  localparam logic [10:0] F_HLT   = 11'b00000000001;

  typedef struct {
    string       name;
    logic [10:0] val;
    int          sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic stimDone = 1'b0;

  task automatic drive(input logic r, input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2, input logic [3:0] d,
                       input logic wr, input logic ld, input logic hlt, input logic br,
                       input logic ms);
    @(posedge clk);
    #1;
    rst = r; ID_Valid = v; SrcReg1 = s1; Src1_Used = u1; SrcReg2 = s2; Src2_Used = u2;
    DstReg = d; RF_WrDec = wr; LoadDec = ld; HltDec = hlt; BranchTaken = br; MemStall = ms;
  endtask

  task automatic bubble(input logic r, input logic ms);
    drive(r, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ms);
  endtask

  task automatic pushExp(input string nm, input logic [10:0] val, input int sc);
    exp_t e;
    e.name = nm; e.val = val; e.sc = sc;
    q.push_back(e);
  endtask

  // monitor: the DUT presents a fresh response every cycle; sample on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e   = q.pop_front();
      act = {PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable, IDEX_Noop,
             XX_Reg1, XX_Reg2, MX_Reg1, MX_Reg2, LoadUseStall, Halted};
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: outputs=%b required=%b", e.name, act, e.val);
      end
      if (e.sc >= 0) begin
        checks++;
        if (StallCount !== 16'(e.sc)) begin
          errors++;
          $display("FAIL %s StallCount: got=%0d required=%0d", e.name, StallCount, e.sc);
        end
      end
    end else if (stimDone) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b0;
    ID_Valid = 0; SrcReg1 = 0; Src1_Used = 0; SrcReg2 = 0; Src2_Used = 0;
    DstReg = 0; RF_WrDec = 0; LoadDec = 0; HltDec = 0; BranchTaken = 0; MemStall = 0;

    // reset holds outputs even with a real instruction in ID
    drive(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); pushExp("reset_hold", RSTV, 0);
    drive(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0); pushExp("reset_hold2", RSTV, 0);

    // forwarding
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("issue_first", RUN_ISS, 0);
    drive(1, 1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0);   pushExp("fwd_xx", RUN_ISS | F_XX1, -1);
    drive(1, 1, 8, 1, 9, 1, 7, 1, 0, 0, 0, 0);   pushExp("indep", RUN_ISS, -1);
    drive(1, 1, 4, 1, 1, 1, 10, 1, 0, 0, 0, 0);  pushExp("fwd_mx", RUN_ISS | F_MX1, -1);
    drive(1, 1, 10, 1, 7, 1, 12, 1, 0, 0, 0, 0); pushExp("fwd_both", RUN_ISS | F_XX1 | F_MX2, -1);
    drive(1, 1, 0, 1, 0, 1, 12, 1, 0, 0, 0, 0);  pushExp("r0_src", RUN_ISS, -1);
    drive(1, 1, 12, 1, 12, 0, 1, 0, 0, 0, 0, 0); pushExp("younger_wins", RUN_ISS | F_XX1, -1);
    drive(1, 1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0);  pushExp("nowr_nofwd", RUN_ISS | F_MX2, -1);

    // load-use
    drive(1, 1, 5, 1, 0, 0, 2, 1, 1, 0, 0, 0);   pushExp("lw_issue", RUN_ISS, -1);
    drive(1, 1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0);   pushExp("load_use", STALL, 0);
    drive(1, 1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0);   pushExp("after_stall", RUN_ISS | F_MX1 | F_MX2, 1);

    // load into r0 never stalls
    drive(1, 1, 9, 1, 0, 0, 0, 1, 1, 0, 0, 0);   pushExp("lw_r0", RUN_ISS, -1);
    drive(1, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0);   pushExp("r0_no_stall", RUN_ISS, 1);

    // branches
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0);   pushExp("branch_flush", RUN_ISS | F_FL, -1);
    bubble(1, 0);                                pushExp("flush_one_cycle", RUN_BUB, -1);
    drive(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);   pushExp("lw_r5", RUN_ISS, -1);
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0);   pushExp("branch_in_stall", STALL, 1);
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0);   pushExp("branch_after_stall", RUN_ISS | F_FL | F_MX1, 2);
    bubble(1, 0);                                pushExp("bubble", RUN_BUB, -1);

    // halt with simultaneous branch: accepted, no flush
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   pushExp("halt_accept", RUN_ISS, -1);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("drain1", DRAINV, -1);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("drain2", DRAINV, -1);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("halted", HALTV, 2);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 1);   pushExp("halted_memstall", FROZEN | F_HLT, -1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);   pushExp("halted_sticky", HALTV, -1);

    // asynchronous reset out of HALTED, mid-cycle
    drive(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("async_reset_halted", RSTV, 0);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("resume", RUN_ISS, 0);

    // MemStall freezes a pending load-use
    drive(1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0);   pushExp("lw_r4", RUN_ISS, -1);
    drive(1, 1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 1);   pushExp("memstall_over_stall", F_LUS, 0);
    drive(1, 1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0);   pushExp("stall_after_freeze", STALL, 0);
    drive(1, 1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0);   pushExp("mx_after_freeze", RUN_ISS | F_MX1, 1);

    // halt with two MemStall cycles inside the drain
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);   pushExp("halt2_accept", RUN_ISS | F_XX1, -1);
    bubble(1, 0);                                pushExp("drain2_1", DRAINV, -1);
    bubble(1, 1);                                pushExp("drain_memstall1", FROZEN, -1);
    bubble(1, 1);                                pushExp("drain_memstall2", FROZEN, -1);
    bubble(1, 0);                                pushExp("drain_resume", DRAINV, -1);
    bubble(1, 0);                                pushExp("halted_delayed", HALTV, 1);

    // reset in the middle of a drain
    bubble(0, 0);                                pushExp("reset2", RSTV, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);   pushExp("halt3_accept", RUN_ISS, 0);
    bubble(1, 0);                                pushExp("drain3_1", DRAINV, -1);
    bubble(0, 0);                                pushExp("reset_mid_drain", RSTV, 0);
    drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);   pushExp("reset_held", RSTV, 0);
    drive(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);   pushExp("resume_issue", RUN_ISS, 0);
    drive(1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);   pushExp("resume_fwd", RUN_ISS | F_XX1, -1);
    bubble(1, 0);                                pushExp("idle", RUN_BUB, 0);

    stimDone = 1'b1;
    repeat (50) @(posedge clk);
    $display("FAIL watchdog: monitor pending=%0d required=0", q.size());
    $fatal(1, "scoreboard did not drain");
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Decode-stage hazard and forwarding controller that drives the ID/EX pipeline register's NoopIn, WriteEnable and forwarding-select inputs (XX_Reg1/2, MX_Reg1/2), plus the PC and IF/ID stall and flush controls. It keeps its own two-entry scoreboard of in-flight destinations (EX slot and MEM slot), inserts load-use bubbles and flushes on taken branches. A halt-drain FSM lets the pipeline empty before asserting Halted.

Parameters:
DRAIN_CYCLES, 3, advancing cycles from halt acceptance to the HALTED state (EX, MEM and WB drain).
CNT_W, 16, width of the saturating load-use stall counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  one clock; reset is asynchronous and active-low.
ID_Valid  in  1  instruction in ID is real, not a bubble.
SrcReg1  in  4  ID source register 1.
SrcReg2  in  4  ID source register 2.
Src1_Used  in  1  instruction reads SrcReg1.
Src2_Used  in  1  instruction reads SrcReg2.
DstReg  in  4  ID destination register.
RF_WrDec  in  1  ID instruction writes the register file.
LoadDec  in  1  ID instruction is a memory load.
HltDec  in  1  ID instruction is HLT.
BranchTaken  in  1  branch resolved taken in ID.
MemStall  in  1  memory busy; freeze the whole pipeline.
PC_WriteEnable  out  1  PC update enable.
IFID_WriteEnable  out  1  IF/ID register enable.
IFID_Flush  out  1  squash IF/ID contents.
IDEX_WriteEnable  out  1  to ID/EX WriteEnable.
IDEX_Noop  out  1  to ID/EX NoopIn (bubble).
XX_Reg1, XX_Reg2  out  1 each  EX-to-EX forward select for operand 1/2.
MX_Reg1, MX_Reg2  out  1 each  MEM-to-EX forward select for operand 1/2.
LoadUseStall  out  1  load-use bubble this cycle.
Halted  out  1  pipeline drained after HLT.
StallCount  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- State: scoreboard ex{dst[3:0],wr,load,v} and mem{dst[3:0],wr,v}; FSM RUN/DRAIN/HALTED; drain counter; StallCount.
- Reset (rst=0, async): all scoreboard v=0, FSM=RUN, counter=DRAIN_CYCLES, StallCount=0, Halted=0. While rst=0, outputs are forced to: PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_WriteEnable=1, IDEX_Noop=1, all other outputs 0.
- match(s, slot) = slot.v & slot.wr & (slot.dst==s) & (s!=0). Register 0 never creates a hazard.
- LoadUseStall = RUN & ID_Valid & ex.v & ex.load & ex.wr & ((Src1_Used & match(SrcReg1,ex)) | (Src2_Used & match(SrcReg2,ex))).
- Forward selects (combinational, valid only when IDEX_Noop=0; otherwise 0):
  - XX_RegN = SrcN_Used & match(SrcRegN, ex) & !ex.load.
  - MX_RegN = SrcN_Used & match(SrcRegN, mem) & !XX_RegN. The younger producer wins.
- Output priority, highest first:
  - MemStall: all write enables 0, IDEX_Noop=0, IFID_Flush=0; no state changes (scoreboard, FSM, counter and StallCount all hold).
  - HALTED: all enables 0, Halted=1 until reset.
  - DRAIN: PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_WriteEnable=1, IDEX_Noop=1.
  - LoadUseStall: PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_Noop=1, IFID_Flush=0. BranchTaken and HltDec are ignored this cycle.
  - RUN normal: all enables 1; IDEX_Noop = !ID_Valid; IFID_Flush = ID_Valid & BranchTaken.
- Scoreboard on every advancing edge (MemStall=0): mem <= ex (load bit dropped). ex <= the ID entry if the ID instruction is issued (RUN, ID_Valid, no LoadUseStall); otherwise ex.v <= 0.
- FSM:
  - RUN -> DRAIN when HltDec & ID_Valid & issued. The HLT itself enters ID/EX normally.
  - DRAIN: counter decrements on each advancing edge. Counter at 1 -> HALTED next edge; counter reloads on entry.
  - HALTED exits only on reset.
- StallCount: +1 per edge where LoadUseStall=1 & MemStall=0; saturates at all-ones.
- Simultaneous BranchTaken & HltDec: the halt is accepted and no flush occurs (DRAIN suppresses fetch anyway).
- Reset mid-DRAIN returns to RUN with an empty scoreboard.

Test Plan:
- Forwarding: ADD r3 then SUB r4,r3,r5 back-to-back -> XX_Reg1=1, MX_Reg1=0. With one independent instruction between them -> MX_Reg1=1, XX_Reg1=0.
- Load-use: LW r2 then ADD r6,r2,r2 -> one cycle of LoadUseStall=1, PC/IFID enables 0, IDEX_Noop=1. Next cycle MX_Reg1=MX_Reg2=1, StallCount=1.
- r0 destination: LW r0 then ADD r1,r0,r0 -> no stall, no forwards asserted.
- Branch: BranchTaken=1 with ID_Valid=1 -> IFID_Flush=1 for exactly one cycle. Same branch during a load-use stall -> IFID_Flush=0.
- Halt: HltDec accepted at cycle N -> IDEX_Noop=1 for cycles N+1..N+3, Halted=1 from cycle N+3 onward. MemStall held 2 cycles during DRAIN -> Halted delayed by exactly 2 cycles.
- Reset: drop rst mid-DRAIN -> Halted=0, StallCount=0, PC_WriteEnable=0 immediately (asynchronously). On release, normal issue resumes.
